note_pattern_gen: RTL and testbench

Parametrised successor to the lab's note-driven display logic. Takes recognised-note events plus key input and produces per-pixel RGB for the raster scanner. Adds key-driven saturating cursor movement and frame-synchronous mode switching. Adds a hold/fade state machine that returns to the default pattern when no note has arrived for a programmable time. Sits between note_recognizer and the VGA/LCD timing block.

---
 rtl/note_pattern_pkg.sv | 25 ++
 rtl/note_pattern_if.sv | 32 +++
 rtl/note_pattern_shader.sv | 88 ++++++++
 rtl/note_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_note_pattern_gen.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_pattern_pkg.sv
// note_pattern_pkg: shared types for the note-driven pattern generator.
// Mode/state encodings match the o_mode/o_state port values.
package note_pattern_pkg;

    typedef enum logic [1:0] {
        SWEEP   = 2'd0,
        HYPER   = 2'd1,
        CIRCLE  = 2'd2,
        DEFAULT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FADE   = 2'd2
    } state_t;

    localparam int n_notes = 12;

    // Twelve semitones fold onto the three animated patterns.
    function automatic mode_t note_mode(input logic [3:0] idx);
        return mode_t'(2'(idx % 4'd3));
    endfunction

endpackage

// File: rtl/note_pattern_if.sv
// note_pattern_if: note/key/raster inputs and pixel/status outputs
// of note_pattern_gen; master = driver side, slave = generator.
interface note_pattern_if #(
    parameter int w_x     = 10,
    parameter int w_y     = 9,
    parameter int w_red   = 4,
    parameter int w_green = 4,
    parameter int w_blue  = 4,
    parameter int w_key   = 4
);
    logic [w_key-1:0]   key;
    logic               note_vld;
    logic [3:0]         note_idx;
    logic               frame_start;
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;
    logic [w_red-1:0]   red;
    logic [w_green-1:0] green;
    logic [w_blue-1:0]  blue;
    logic [1:0]         mode;
    logic [1:0]         state;

    modport master (
        output key, note_vld, note_idx, frame_start, x, y,
        input  red, green, blue, mode, state
    );

    modport slave (
        input  key, note_vld, note_idx, frame_start, x, y,
        output red, green, blue, mode, state
    );
endinterface

// File: rtl/note_pattern_shader.sv
// note_pattern_shader: combinational pattern colour for one pixel,
// attenuated by a right shift of the current fade level.
module note_pattern_shader
    import note_pattern_pkg::*;
#(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = 10,
    parameter int w_y           = 9,
    parameter int w_red         = 4,
    parameter int w_green       = 4,
    parameter int w_blue        = 4,
    parameter int w_lvl         = 3
) (
    input  mode_t              i_mode,
    input  logic [w_x-1:0]     i_x,
    input  logic [w_y-1:0]     i_y,
    input  logic [w_x-1:0]     i_cnt1,
    input  logic [w_y-1:0]     i_cnt2,
    input  logic [w_lvl-1:0]   i_fade,
    output logic [w_red-1:0]   o_red,
    output logic [w_green-1:0] o_green,
    output logic [w_blue-1:0]  o_blue
);
    localparam int w_m = ((w_x > w_y) ? w_x : w_y) + 1;
    localparam int w_p = 2 * w_m + 1;
    localparam logic [w_p-1:0] L_HYP =
        w_p'(screen_width * screen_height / 16);
    localparam logic [w_p-1:0] L_CIR =
        w_p'(screen_width * screen_height / 12);

    logic [w_m-1:0] w_xe, w_ye, w_c1e, w_c2e;
    logic [w_m-1:0] w_sum, w_dif, w_ax, w_ay;
    logic signed [w_m-1:0] w_dx, w_dy;
    logic [w_p-1:0] w_pr, w_sq;
    logic w_lt_x, w_lt_y;
    logic [w_red-1:0]   w_r;
    logic [w_green-1:0] w_g;
    logic [w_blue-1:0]  w_b;

    assign w_xe  = w_m'(i_x);
    assign w_ye  = w_m'(i_y);
    assign w_c1e = w_m'(i_cnt1);
    assign w_c2e = w_m'(i_cnt2);
    assign w_sum = w_xe + w_ye;
    assign w_dif = w_xe - w_ye;
    assign w_dx  = $signed(w_xe - w_c1e);
    assign w_dy  = $signed(w_ye - w_c2e);
    assign w_ax  = w_dx[w_m-1] ? $unsigned(-w_dx) : $unsigned(w_dx);
    assign w_ay  = w_dy[w_m-1] ? $unsigned(-w_dy) : $unsigned(w_dy);
    // Full-width products so the shape tests never wrap.
    assign w_pr  = w_p'(w_ax) * w_p'(w_ay);
    assign w_sq  = w_p'(w_ax) * w_p'(w_ax) + w_p'(w_ay) * w_p'(w_ay);
    assign w_lt_x = i_x < i_cnt1;
    assign w_lt_y = i_y < i_cnt2;

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        unique case (i_mode)
            SWEEP: if (w_lt_x) begin
                w_r = w_red'(w_sum >> 3);
                w_g = w_green'(w_dif >> 3);
                w_b = w_blue'(w_xe >> 3);
            end
            HYPER: if (w_pr < L_HYP) begin
                w_r = w_red'(w_xe >> 3);
                w_g = w_green'(w_ye >> 3);
                w_b = '1;
            end
            CIRCLE: if (w_sq < L_CIR) begin
                w_r = '1;
                w_g = '1;
                w_b = w_blue'(w_sum >> 3);
            end
            DEFAULT: begin
                if (w_lt_x) w_r = '1;
                else        w_b = '1;
                if (w_lt_y) w_g = '1;
            end
        endcase
    end

    assign o_red   = w_r >> i_fade;
    assign o_green = w_g >> i_fade;
    assign o_blue  = w_b >> i_fade;
endmodule

// File: rtl/note_pattern_gen.sv
// note_pattern_gen: note-driven pixel colour with key cursor and
// hold/fade FSM. Fade state/shift enabled by NOTE_PATTERN_FADE_EN.
module note_pattern_gen
    import note_pattern_pkg::*;
#(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_red         = 4,
    parameter int w_green       = 4,
    parameter int w_blue        = 4,
    parameter int w_key         = 4,
    parameter int w_tick        = 20,
    parameter int hold_ticks    = 16,
    parameter int fade_steps    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    note_pattern_if.slave bus
);
    localparam int HOLD_W = $clog2(hold_ticks + 1);
    localparam int LVL_W  = $clog2(fade_steps + 1);
    localparam logic [w_x-1:0]    L_XMAX = w_x'(screen_width - 1);
    localparam logic [w_y-1:0]    L_YMAX = w_y'(screen_height - 1);
    localparam logic [w_y-1:0]    L_YMID = w_y'(screen_height / 2);
    localparam logic [HOLD_W-1:0] L_HOLD = HOLD_W'(hold_ticks);
    localparam logic [LVL_W-1:0]  L_FADE = LVL_W'(fade_steps);

    logic [w_tick-1:0]  r_presc;
    logic [w_x-1:0]     r_cnt1;
    logic [w_y-1:0]     r_cnt2;
    logic [HOLD_W-1:0]  r_hold, w_hold_nx;
    logic [LVL_W-1:0]   r_lvl, w_lvl_nx, r_fade;
    state_t             r_state, w_state_nx;
    mode_t              r_pend, w_pend_nx, r_mode;
    logic [w_red-1:0]   r_red, w_pix_r;
    logic [w_green-1:0] r_green, w_pix_g;
    logic [w_blue-1:0]  r_blue, w_pix_b;
    logic w_tk, w_note, w_dn, w_up;

    assign w_tk   = (r_presc == '0);
    assign w_note = bus.note_vld && (bus.note_idx < 4'(n_notes));
    assign w_dn   = bus.key[0] && !(|bus.key[w_key-1:1]);
    assign w_up   = !bus.key[0] && (|bus.key[w_key-1:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= L_YMID;
        end else begin
            r_presc <= r_presc + w_tick'(1);
            if (w_tk) begin
                r_cnt1 <= (r_cnt1 == L_XMAX) ? '0 : r_cnt1 + w_x'(1);
                if (w_dn && r_cnt2 != L_YMAX)
                    r_cnt2 <= r_cnt2 + w_y'(1);
                else if (w_up && r_cnt2 != '0)
                    r_cnt2 <= r_cnt2 - w_y'(1);
            end
        end
    end

    // A valid note outranks a coincident tick.
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_lvl_nx   = r_lvl;
        w_pend_nx  = r_pend;
        if (w_note) begin
            w_state_nx = ACTIVE;
            w_hold_nx  = L_HOLD;
            w_lvl_nx   = '0;
            w_pend_nx  = note_mode(bus.note_idx);
        end else if (w_tk) begin
            unique case (r_state)
                ACTIVE: if (r_hold == '0) begin
`ifdef NOTE_PATTERN_FADE_EN
                    w_state_nx = FADE;
`else
                    w_state_nx = IDLE;
                    w_pend_nx  = DEFAULT;
`endif
                end else begin
                    w_hold_nx = r_hold - HOLD_W'(1);
                end
                FADE: if (r_lvl == L_FADE) begin
                    w_state_nx = IDLE;
                    w_pend_nx  = DEFAULT;
                    w_lvl_nx   = '0;
                end else begin
                    w_lvl_nx = r_lvl + LVL_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_lvl   <= '0;
            r_pend  <= DEFAULT;
        end else begin
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_lvl   <= w_lvl_nx;
            r_pend  <= w_pend_nx;
        end
    end

    note_pattern_shader #(
        .screen_width (screen_width),
        .screen_height(screen_height),
        .w_x          (w_x),
        .w_y          (w_y),
        .w_red        (w_red),
        .w_green      (w_green),
        .w_blue       (w_blue),
        .w_lvl        (LVL_W)
    ) u_shader (
        .i_mode (r_mode),
        .i_x    (bus.x),
        .i_y    (bus.y),
        .i_cnt1 (r_cnt1),
        .i_cnt2 (r_cnt2),
        .i_fade (r_fade),
        .o_red  (w_pix_r),
        .o_green(w_pix_g),
        .o_blue (w_pix_b)
    );

    // Mode and fade only change at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= DEFAULT;
            r_fade  <= '0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            if (bus.frame_start) begin
                r_mode <= r_pend;
                r_fade <= r_lvl;
            end
            r_red   <= w_pix_r;
            r_green <= w_pix_g;
            r_blue  <= w_pix_b;
        end
    end

    assign bus.red   = r_red;
    assign bus.green = r_green;
    assign bus.blue  = r_blue;
    assign bus.mode  = r_mode;
    assign bus.state = r_state;
endmodule

// File: tb/tb_note_pattern_gen.sv
// tb_note_pattern_gen: directed + random stimulus against a
// tick-count reference model of note_pattern_gen.
module tb_note_pattern_gen;
    import note_pattern_pkg::*;

    localparam int W      = 640;
    localparam int H      = 480;
    localparam int HOLD   = 2;
    localparam int FSTEPS = 2;
    localparam int TICK   = 16;
    localparam int IDLE_K = 1000;
`ifdef NOTE_PATTERN_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    // Model: cursor, ticks since last valid note, note mode, display regs.
    int m_c1, m_c2, m_k, m_nm, m_mode, m_fade, m_cyc;
    int m_r, m_g, m_b;

    note_pattern_if #(
        .w_x(10), .w_y(9), .w_red(4), .w_green(4), .w_blue(4), .w_key(4)
    ) bus ();

    note_pattern_gen #(
        .screen_width(W), .screen_height(H),
        .w_tick(4), .hold_ticks(HOLD), .fade_steps(FSTEPS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int st_of(input int k);
        if (k <= HOLD) return 1;
        if (FADE_EN && k <= HOLD + 1 + FSTEPS) return 2;
        return 0;
    endfunction

    function automatic int lvl_of(input int k);
        return (st_of(k) == 2) ? k - HOLD - 1 : 0;
    endfunction

    task automatic shade(input int md, input int x, input int y,
                         input int c1, input int c2, input int f,
                         output int r, output int g, output int b);
        int ax, ay;
        ax = (x > c1) ? x - c1 : c1 - x;
        ay = (y > c2) ? y - c2 : c2 - y;
        r = 0; g = 0; b = 0;
        case (md)
            0: if (x < c1) begin
                r = ((x + y) >> 3) & 15;
                g = ((x - y) >> 3) & 15;
                b = (x >> 3) & 15;
            end
            1: if (ax * ay < W * H / 16) begin
                r = (x >> 3) & 15;
                g = (y >> 3) & 15;
                b = 15;
            end
            2: if (ax * ax + ay * ay < W * H / 12) begin
                r = 15; g = 15;
                b = ((x + y) >> 3) & 15;
            end
            default: begin
                if (x < c1) r = 15; else b = 15;
                if (y < c2) g = 15;
            end
        endcase
        r = r >> f; g = g >> f; b = b >> f;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input int exp);
        logic [31:0] e;
        e = exp;
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic model_reset();
        m_c1 = 0; m_c2 = H / 2; m_k = IDLE_K; m_nm = 0;
        m_mode = 3; m_fade = 0; m_cyc = 0;
        m_r = 0; m_g = 0; m_b = 0;
    endtask

    task automatic cyc();
        int er, eg, eb, d;
        bit tk, nv;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            shade(m_mode, int'(bus.x), int'(bus.y), m_c1, m_c2, m_fade,
                  er, eg, eb);
            tk = (m_cyc % TICK) == 0;
            nv = bus.note_vld && (bus.note_idx < 4'd12);
            if (bus.frame_start) begin
                m_mode = (st_of(m_k) == 0) ? 3 : m_nm;
                m_fade = lvl_of(m_k);
            end
            if (tk) begin
                m_c1 = (m_c1 + 1) % W;
                d = 0;
                if (bus.key[0] && bus.key[3:1] == 3'd0) d = 1;
                if (!bus.key[0] && bus.key[3:1] != 3'd0) d = -1;
                m_c2 = m_c2 + d;
                if (m_c2 < 0) m_c2 = 0;
                if (m_c2 > H - 1) m_c2 = H - 1;
            end
            if (nv) begin
                m_k = 0;
                m_nm = int'(bus.note_idx) % 3;
            end else if (tk && m_k < IDLE_K) begin
                m_k++;
            end
            m_cyc++;
            m_r = er; m_g = eg; m_b = eb;
        end
        #1;
        check("red", bus.red, m_r);
        check("green", bus.green, m_g);
        check("blue", bus.blue, m_b);
        check("mode", bus.mode, m_mode);
        check("state", bus.state, rst_n ? st_of(m_k) : 0);
    endtask

    task automatic idle_in();
        bus.note_vld = 1'b0;
        bus.note_idx = 4'd0;
        bus.frame_start = 1'b0;
        bus.key = 4'd0;
        bus.x = 10'($urandom_range(0, W - 1));
        bus.y = 9'($urandom_range(0, H - 1));
    endtask

    task automatic rand_in(input int note_div, input int fs_div);
        bus.x = 10'($urandom_range(0, W - 1));
        bus.y = 9'($urandom_range(0, H - 1));
        bus.key = 4'($urandom);
        bus.note_vld = ($urandom_range(0, note_div - 1) == 0);
        bus.note_idx = 4'($urandom);
        bus.frame_start = ($urandom_range(0, fs_div - 1) == 0);
    endtask

    task automatic probe_g(input string tag, input int y, input int exp);
        idle_in();
        bus.x = 10'd0;
        bus.y = 9'(y);
        cyc();
        check(tag, bus.green, exp);
    endtask

    int seq[$];
    int exp_seq[$];
    bit found;

    initial begin
        model_reset();
        idle_in();
        repeat (3) cyc();
        rst_n = 1'b1;
        check("rst_mode", bus.mode, 3);
        check("rst_state", bus.state, 0);
        check("rst_rgb", {bus.red, bus.green, bus.blue}, 0);

        repeat (2000) begin rand_in(40, 50); cyc(); end

        // Asynchronous reset mid-run.
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb", {bus.red, bus.green, bus.blue}, 0);
        check("arst_mode", bus.mode, 3);
        check("arst_state", bus.state, 0);
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        probe_g("cnt2_239", 239, 15);
        probe_g("cnt2_240", 240, 0);

        // Note mid-frame: mode waits for frame_start.
        idle_in();
        bus.note_vld = 1'b1;
        bus.note_idx = 4'd4;
        cyc();
        check("note_state", bus.state, 1);
        check("note_mode_hold", bus.mode, 3);
        idle_in();
        repeat (5) cyc();
        check("mode_mid_frame", bus.mode, 3);
        bus.frame_start = 1'b1;
        cyc();
        check("mode_frame", bus.mode, 1);

        // Hold then fade, watched at the cursor centre.
        idle_in();
        bus.note_vld = 1'b1;
        bus.note_idx = 4'd2;
        bus.frame_start = 1'b1;
        bus.x = 10'(m_c1);
        bus.y = 9'(m_c2);
        cyc();
        bus.note_vld = 1'b0;
        for (int i = 0; i < 150; i++) begin
            bus.x = 10'(m_c1);
            bus.y = 9'(m_c2);
            cyc();
            if (i >= 2 && (seq.size() == 0 || seq[$] != int'(bus.red)))
                seq.push_back(int'(bus.red));
        end
        exp_seq = FADE_EN ? '{15, 7, 3, 0} : '{15, 0};
        check("fade_len", seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
            check($sformatf("fade_step%0d", i), seq[i], exp_seq[i]);
        check("fade_idle", bus.state, 0);
        check("fade_mode", bus.mode, 3);

        // Cursor saturation, both directions.
        for (int i = 0; i < 300 * TICK; i++) begin
            idle_in();
            bus.key = 4'b0001;
            bus.frame_start = ($urandom_range(0, 63) == 0);
            cyc();
        end
        probe_g("sat_hi_478", 478, 15);
        probe_g("sat_hi_479", 479, 0);
        for (int i = 0; i < 500 * TICK; i++) begin
            idle_in();
            bus.key = 4'b0010;
            bus.frame_start = ($urandom_range(0, 63) == 0);
            cyc();
        end
        probe_g("sat_lo_0", 0, 0);

        // Note on a tick with hold at 1 reloads the hold.
        idle_in();
        bus.note_vld = 1'b1;
        cyc();
        idle_in();
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_k == 1 && (m_cyc % TICK) == 0) found = 1'b1;
            else cyc();
        end
        check("tick_align", found, 1);
        bus.note_vld = 1'b1;
        bus.note_idx = 4'd5;
        cyc();
        idle_in();
        check("coinc_state", bus.state, 1);
        repeat (33) cyc();
        check("reload_active", bus.state, 1);

        // Out-of-range note index is ignored.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (bus.state == 2'd0) found = 1'b1;
        end
        check("wait_idle", found, 1);
        bus.note_vld = 1'b1;
        bus.note_idx = 4'd13;
        cyc();
        idle_in();
        check("ign_state", bus.state, 0);
        bus.frame_start = 1'b1;
        cyc();
        check("ign_mode", bus.mode, 3);

        repeat (3000) begin rand_in(25, 20); cyc(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
